// File: rtl/root_job_dispatcher.sv
// Queues root-extraction jobs, issues them one at a time to an external root engine,
// and returns tagged results (or errors for degree-0 jobs and engine timeouts) in FIFO order.
module root_job_dispatcher #(
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 1023
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [9:0]  req_radicand,
    input  logic [2:0]  req_degree,
    input  logic [3:0]  req_tag,
    output logic        eng_in_valid,
    output logic [9:0]  eng_in_data_1,
    output logic [2:0]  eng_in_data_2,
    input  logic        eng_out_valid,
    input  logic [19:0] eng_out_data,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [19:0] rsp_data,
    output logic [3:0]  rsp_tag,
    output logic        rsp_err,
    output logic        busy,
    output logic [1:0]  dbg_state
);
    // Handshakes: a transfer happens on any rising edge where valid && ready are both high;
    // valid is held with stable payload until that edge.
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

    state_t          r_state, w_state_next;
    logic [16:0]     r_mem [DEPTH];
    logic [AW-1:0]   r_wr_ptr, r_rd_ptr;
    logic [CW-1:0]   r_count;
    logic [9:0]      r_timer;
    logic            r_eng_in_valid;
    logic [9:0]      r_eng_data_1;
    logic [2:0]      r_eng_data_2;
    logic            r_rsp_valid;
    logic [19:0]     r_rsp_data;
    logic [3:0]      r_rsp_tag;
    logic            r_rsp_err;

    logic            w_full, w_empty, w_push, w_pop;
    logic            w_start, w_ld_ok, w_ld_err;
    logic [16:0]     w_head;
    logic [9:0]      w_head_rad;
    logic [2:0]      w_head_deg;
    logic [3:0]      w_head_tag;

    assign w_full     = (r_count == CW'(DEPTH));
    assign w_empty    = (r_count == '0);
    assign req_ready  = rst_n && !w_full;
    assign w_push     = req_valid && req_ready;
    assign w_head     = r_mem[r_rd_ptr];
    assign w_head_rad = w_head[16:7];
    assign w_head_deg = w_head[6:4];
    assign w_head_tag = w_head[3:0];

    assign busy          = rst_n && ((r_state != S_IDLE) || !w_empty);
    assign eng_in_valid  = r_eng_in_valid;
    assign eng_in_data_1 = r_eng_data_1;
    assign eng_in_data_2 = r_eng_data_2;
    assign rsp_valid     = r_rsp_valid;
    assign rsp_data      = r_rsp_data;
    assign rsp_tag       = r_rsp_tag;
    assign rsp_err       = r_rsp_err;
    assign dbg_state     = r_state;

    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        w_pop        = 1'b0;
        w_start      = 1'b0;
        w_ld_ok      = 1'b0;
        w_ld_err     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!w_empty) begin
                    if (w_head_deg != 3'd0) begin
                        w_start      = 1'b1;
                        w_state_next = S_ISSUE;
                    end else begin
                        w_pop        = 1'b1;
                        w_ld_err     = 1'b1;
                        w_state_next = S_RESP;
                    end
                end
            end
            S_ISSUE: w_state_next = S_WAIT;
            S_WAIT: begin
                // A result arriving in the timeout cycle still counts as a success.
                if (eng_out_valid) begin
                    w_pop        = 1'b1;
                    w_ld_ok      = 1'b1;
                    w_state_next = S_RESP;
                end else if (r_timer == 10'(TIMEOUT)) begin
                    w_pop        = 1'b1;
                    w_ld_err     = 1'b1;
                    w_state_next = S_RESP;
                end
            end
            S_RESP: begin
                if (rsp_ready) w_state_next = S_IDLE;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= {req_radicand, req_degree, req_tag};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_timer        <= '0;
            r_eng_in_valid <= 1'b0;
            r_eng_data_1   <= '0;
            r_eng_data_2   <= '0;
            r_rsp_valid    <= 1'b0;
            r_rsp_data     <= '0;
            r_rsp_tag      <= '0;
            r_rsp_err      <= 1'b0;
        end else begin
            r_eng_in_valid <= w_start;
            if (w_start) begin
                r_eng_data_1 <= w_head_rad;
                r_eng_data_2 <= w_head_deg;
            end
            // Clearing during ISSUE makes the first WAIT cycle read zero.
            if (r_state == S_ISSUE)     r_timer <= '0;
            else if (r_state == S_WAIT) r_timer <= r_timer + 1'b1;
            if (w_ld_ok) begin
                r_rsp_valid <= 1'b1;
                r_rsp_data  <= eng_out_data;
                r_rsp_tag   <= w_head_tag;
                r_rsp_err   <= 1'b0;
            end else if (w_ld_err) begin
                r_rsp_valid <= 1'b1;
                r_rsp_data  <= '0;
                r_rsp_tag   <= w_head_tag;
                r_rsp_err   <= 1'b1;
            end else if (r_state == S_RESP && rsp_ready) begin
                r_rsp_valid <= 1'b0;
            end
        end
    end

endmodule
